button_debouncer: RTL

- Synchronises and debounces a raw asynchronous level input, such as a board push-button or a UART control strobe, into a clean level on the `clk` domain.
- Sits directly upstream of `single_pulser`: `signal_out` here drives `single_pulser.signal_in`.
- A level change is accepted only after it has held stable for `STABLE_CYCLES` consecutive synchronised samples. Shorter excursions are rejected as glitches.

---
 rtl/debounce_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/button_debouncer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Brief    : Shared types and constants for the button debouncer slice:
//            FSM state encoding, default timing parameters and the
//            saturation limit of the optional glitch counter.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Debounce FSM states; encoding is fixed so it can be probed externally.
  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  // 500000 cycles is ~10 ms at 50 MHz, a typical mechanical bounce window.
  localparam int DEFAULT_STABLE_CYCLES = 500000;
  localparam int DEFAULT_CNT_WIDTH     = 20;

  // Glitch counter saturates here rather than wrapping.
  localparam logic [7:0] GLITCH_CNT_MAX = 8'd255;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for a single asynchronous level. Both
//            stages clear to 0 on the asynchronous active-low reset. Also
//            suitable for the UART RX line.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync1;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Synchronises a raw asynchronous level and only passes a new
//            level to signal_out once it has held for STABLE_CYCLES samples
//            beyond the first. Shorter excursions are dropped as glitches.
//            Optional feature macro: BUTTON_DEBOUNCER_GLITCH_COUNT_EN adds a
//            saturating 8-bit count of rejected glitches on glitch_count.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       signal_in,
`ifdef BUTTON_DEBOUNCER_GLITCH_COUNT_EN
  output logic [7:0] glitch_count,
`endif
  output logic       signal_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_TARGET = CNT_WIDTH'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;

  logic                 sync_level;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 out_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (signal_in),
    .q     (sync_level)
  );

  // State, stability counter and the registered output level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_LOW;
      cnt        <= CNT_ZERO;
      signal_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      signal_out <= out_nxt;
    end
  end

  // Next-state logic: a wait state either restarts on bounce or accepts
  // once cnt has reached the target with the new level still present.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = signal_out;
    case (state)
      S_LOW: begin
        if (sync_level) begin
          state_nxt = S_WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync_level) begin
          state_nxt = S_LOW;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_TARGET) begin
          state_nxt = S_HIGH;
          out_nxt   = 1'b1;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_level) begin
          state_nxt = S_WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_WAIT_LOW: begin
        if (sync_level) begin
          state_nxt = S_HIGH;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_TARGET) begin
          state_nxt = S_LOW;
          out_nxt   = 1'b0;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = CNT_ZERO;
        out_nxt   = 1'b0;
      end
    endcase
  end

`ifdef BUTTON_DEBOUNCER_GLITCH_COUNT_EN
  logic glitch_reject;

  // A rejection is any wait state falling back to the current stable level.
  assign glitch_reject = ((state == S_WAIT_HIGH) && !sync_level) ||
                         ((state == S_WAIT_LOW)  &&  sync_level);

  // Saturating count of rejected glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_count <= 8'd0;
    end else if (glitch_reject && (glitch_count != GLITCH_CNT_MAX)) begin
      glitch_count <= glitch_count + 8'd1;
    end
  end
`endif

endmodule : button_debouncer
`default_nettype wire
